// File: rtl/drum_step_recorder.sv
// drum_step_recorder
//   Live pattern recorder for the 4-instrument step sequencer. Pad hits are
//   edge-detected, quantized to the step grid driven by step_tick, and set as
//   bits in four STEPS-wide pattern words.
//   Optional feature macro: DRUM_REC_QUANTIZE_EN
//     defined   -> hits round to the nearest step using the measured period
//     undefined -> hits truncate to the current step
//   state_dbg and period_dbg expose the FSM state and the measured step period.
module drum_step_recorder #(
   parameter int STEPS = 8,
   parameter int CNT_W = 26,
   localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step_tick,
   input  logic             arm,
   input  logic             clear,
   input  logic [3:0]       hit,
   output logic [STEPS-1:0] ins1_pat,
   output logic [STEPS-1:0] ins2_pat,
   output logic [STEPS-1:0] ins3_pat,
   output logic [STEPS-1:0] ins4_pat,
   output logic [IDX_W-1:0] step_idx,
   output logic             recording,
   output logic [1:0]       state_dbg,
   output logic [CNT_W-1:0] period_dbg
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SYNC    = 2'd1,
      S_MEASURE = 2'd2,
      S_RECORD  = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [IDX_W-1:0] step_d;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] period;
   logic [3:0]       hit_prev;
   logic [3:0]       rise;
   logic [IDX_W-1:0] next_step;
   logic [IDX_W-1:0] target;
   logic [STEPS-1:0] pat_q [4];

   assign rise      = hit & ~hit_prev;
   assign next_step = step_idx + IDX_W'(1);   // STEPS is a power of 2, so this wraps

   // Pick the step a rise in this cycle lands on.
   always_comb begin
      target = step_idx;
      if (step_tick) begin
         // A hit on the boundary belongs to the step that is just starting.
         target = next_step;
      end else begin
`ifdef DRUM_REC_QUANTIZE_EN
         // Hits in the later half of a step are pulled forward to the next one.
         if (cnt >= (period >> 1)) target = next_step;
`else
         target = step_idx;
`endif
      end
   end

   // FSM next state and next step index; arm low aborts from any active state.
   always_comb begin
      state_d = state_q;
      step_d  = step_idx;
      case (state_q)
         S_IDLE: begin
            if (arm) state_d = S_SYNC;
         end
         S_SYNC: begin
            if (!arm) begin
               state_d = S_IDLE;
               step_d  = '0;
            end else if (step_tick) begin
               state_d = S_MEASURE;
            end
         end
         S_MEASURE: begin
            if (!arm) begin
               state_d = S_IDLE;
               step_d  = '0;
            end else if (step_tick) begin
               state_d = S_RECORD;
               step_d  = '0;
            end
         end
         S_RECORD: begin
            if (!arm) begin
               state_d = S_IDLE;
               step_d  = '0;
            end else if (step_tick) begin
               step_d = next_step;
            end
         end
         default: begin
            state_d = S_IDLE;
            step_d  = '0;
         end
      endcase
   end

   // FSM state, step index and the registered recording flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         step_idx  <= '0;
         recording <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_idx  <= step_d;
         recording <= (state_d == S_RECORD);
      end
   end

   // Cycles since the last tick (saturating) and the measured tick period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         period <= '0;
      end else begin
         if (step_tick) cnt <= '0;
         else if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
         if (step_tick && (state_q == S_MEASURE || state_q == S_RECORD))
            period <= (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
      end
   end

   // Previous pad levels for rising-edge detection; a held pad writes once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) hit_prev <= 4'b0;
      else       hit_prev <= hit;
   end

   // Pattern words: clear wins, otherwise rises set bits only while recording.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) pat_q[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < 4; i++) pat_q[i] <= '0;
      end else if (state_q == S_RECORD) begin
         for (int i = 0; i < 4; i++)
            if (rise[i]) pat_q[i][target] <= 1'b1;
      end
   end

   assign ins1_pat   = pat_q[0];
   assign ins2_pat   = pat_q[1];
   assign ins3_pat   = pat_q[2];
   assign ins4_pat   = pat_q[3];
   assign state_dbg  = state_q;
   assign period_dbg = period;

endmodule

// File: tb/tb_drum_step_recorder.sv
// Bench for drum_step_recorder: randomized and directed stimulus, a reference
// model expressed as "armed / ticks seen / step / cycles since tick", and a
// monitor that pops one expected output vector per clock.
module tb_drum_step_recorder;
   localparam int STEPS   = 8;
   localparam int CNT_W   = 26;
   localparam int IDX_W   = 3;
   localparam int W       = 4 * STEPS + IDX_W + 1 + CNT_W;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             step_tick = 1'b0;
   logic             arm = 1'b0;
   logic             clear = 1'b0;
   logic [3:0]       hit = 4'b0;
   logic [STEPS-1:0] ins1_pat, ins2_pat, ins3_pat, ins4_pat;
   logic [IDX_W-1:0] step_idx;
   logic             recording;
   logic [1:0]       state_dbg;
   logic [CNT_W-1:0] period_dbg;

   int checks = 0;
   int errors = 0;
   bit done = 1'b0;
   logic [W-1:0] exp_q [$];
   logic [W-1:0] mon_exp;
   logic [W-1:0] mon_act;

   // clock / reset
   always #5 clk = ~clk;

   drum_step_recorder #(.STEPS(STEPS), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .step_tick(step_tick), .arm(arm), .clear(clear),
      .hit(hit), .ins1_pat(ins1_pat), .ins2_pat(ins2_pat), .ins3_pat(ins3_pat),
      .ins4_pat(ins4_pat), .step_idx(step_idx), .recording(recording),
      .state_dbg(state_dbg), .period_dbg(period_dbg)
   );

   // reference model
   logic [STEPS-1:0] m_pat [4];
   logic [3:0]       m_prev;
   bit               m_armed;
   int               m_ticks;   // ticks seen since arming (capped at 2)
   int               m_step;
   int               m_cnt;
   int               m_period;

   function automatic bit m_rec();
      return m_armed && (m_ticks >= 2);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_pat[i] = '0;
      m_prev = 4'b0; m_armed = 1'b0; m_ticks = 0; m_step = 0; m_cnt = 0; m_period = 0;
   endtask

   task automatic model_edge(input bit a, input bit t, input bit c, input logic [3:0] h);
      logic [3:0] r;
      int tgt;
      r = h & ~m_prev;
      if (m_rec()) begin
         if (t) tgt = (m_step + 1) % STEPS;
`ifdef DRUM_REC_QUANTIZE_EN
         else if (m_cnt >= m_period / 2) tgt = (m_step + 1) % STEPS;
`endif
         else tgt = m_step;
         for (int i = 0; i < 4; i++) if (r[i]) m_pat[i][tgt] = 1'b1;
      end
      if (c) for (int i = 0; i < 4; i++) m_pat[i] = '0;
      m_prev = h;
      if (t && m_armed && m_ticks >= 1) m_period = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      if (t) m_cnt = 0;
      else if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (!m_armed) begin
         if (a) begin m_armed = 1'b1; m_ticks = 0; end
      end else if (!a) begin
         m_armed = 1'b0; m_ticks = 0; m_step = 0;
      end else if (t) begin
         if (m_ticks < 2) begin m_ticks++; m_step = 0; end
         else m_step = (m_step + 1) % STEPS;
      end
   endtask

   function automatic logic [W-1:0] model_pack();
      return {m_pat[3], m_pat[2], m_pat[1], m_pat[0], IDX_W'(m_step), m_rec(), CNT_W'(m_period)};
   endfunction

   // driver
   int tick_gap = 100;
   int tick_ph  = 5;
   bit rand_gap = 1'b0;
   bit arm_v = 1'b0;
   bit clr_v = 1'b0;
   logic [3:0] hit_v = 4'b0;

   task automatic drive_and_push();
      step_tick = (tick_ph == 0);
      if (step_tick) tick_ph = (rand_gap ? $urandom_range(20, 120) : tick_gap) - 1;
      else tick_ph--;
      arm = arm_v; clear = clr_v; hit = hit_v;
      model_edge(arm_v, step_tick, clr_v, hit_v);
      exp_q.push_back(model_pack());
      clr_v = 1'b0;
   endtask

   task automatic cyc();
      @(negedge clk);
      drive_and_push();
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic after_edge();
      @(posedge clk); #2;
   endtask

   task automatic goto_pt(input int s, input int c);
      int n = 0;
      while (!(m_rec() && m_step == s && m_cnt == c) && n < 2000) begin cyc(); n++; end
      checks++;
      if (n >= 2000) begin errors++; $display("FAIL goto step %0d cnt %0d: timed out", s, c); end
   endtask

   task automatic wait_recording();
      int n = 0;
      while (!recording && n < 500) begin cyc(); n++; end
      checks++;
      if (n >= 500) begin errors++; $display("FAIL wait_recording: got %0b expected 1", recording); end
   endtask

   task automatic pulse_hit(input int i);
      hit_v[i] = 1'b1; cyc(); hit_v[i] = 1'b0;
   endtask

   task automatic release_reset();
      model_reset();
      exp_q.delete();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      drive_and_push();
   endtask

   // scoreboard monitor
   initial begin
      forever begin
         @(posedge clk); #1;
         if (!reset && !done) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL monitor: got an output cycle expected a queued expectation");
            end else begin
               mon_exp = exp_q.pop_front();
               mon_act = {ins4_pat, ins3_pat, ins2_pat, ins1_pat, step_idx, recording, period_dbg};
               if (mon_act !== mon_exp) begin
                  errors++;
                  $display("FAIL cycle @%0t: got %0h expected %0h", $time, mon_act, mon_exp);
               end
            end
         end
      end
   end

   // stimulus
   initial begin
      release_reset();

      // record session from zeroed patterns
      arm_v = 1'b1;
      wait_recording();
      check_val("rec_step0", {31'b0, recording} + {29'b0, step_idx}, 32'h1);

      goto_pt(0, 10); pulse_hit(0); after_edge();
      check_val("early_hit_ins1", ins1_pat, 8'h01);

      goto_pt(3, 70); pulse_hit(1); after_edge();
`ifdef DRUM_REC_QUANTIZE_EN
      check_val("late_hit_ins2", ins2_pat, 8'h10);
`else
      check_val("late_hit_ins2", ins2_pat, 8'h08);
`endif

      goto_pt(7, 80); hit_v[2] = 1'b1; cyc(); after_edge();
`ifdef DRUM_REC_QUANTIZE_EN
      check_val("wrap_ins3", ins3_pat, 8'h01);
`else
      check_val("wrap_ins3", ins3_pat, 8'h80);
`endif
      repeat (300) cyc();
      after_edge();
`ifdef DRUM_REC_QUANTIZE_EN
      check_val("held_ins3", ins3_pat, 8'h01);
`else
      check_val("held_ins3", ins3_pat, 8'h80);
`endif
      hit_v[2] = 1'b0;

      goto_pt(2, 99); pulse_hit(3); after_edge();
      check_val("tick_hit_ins4", ins4_pat, 8'h08);

      goto_pt(5, 20); clr_v = 1'b1; pulse_hit(0); after_edge();
      check_val("clear_beats_hit", {ins4_pat, ins3_pat, ins2_pat, ins1_pat}, 32'h0);
      arm_v = 1'b0; cyc(); after_edge();
      check_val("disarm_rec", {31'b0, recording}, 32'h0);
      check_val("disarm_step", {29'b0, step_idx}, 32'h0);
      for (int k = 0; k < 4; k++) begin repeat (7) cyc(); pulse_hit(k); end
      repeat (2) cyc(); after_edge();
      check_val("idle_ignored", {ins4_pat, ins3_pat, ins2_pat, ins1_pat}, 32'h0);

      // randomized phase: random tick spacing, pads, clears and arm drops
      rand_gap = 1'b1;
      arm_v = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 3) == 0) hit_v = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 149) == 0) clr_v = 1'b1;
         if (arm_v) begin if ($urandom_range(0, 599) == 0) arm_v = 1'b0; end
         else if ($urandom_range(0, 19) == 0) arm_v = 1'b1;
         cyc();
      end

      // reset in the middle of a recording with patterns populated
      rand_gap = 1'b0;
      arm_v = 1'b1;
      wait_recording();
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 2) == 0) hit_v = 4'($urandom_range(0, 15));
         cyc();
      end
      @(negedge clk); reset = 1'b1; #1;
      check_val("reset_pats", {ins4_pat, ins3_pat, ins2_pat, ins1_pat}, 32'h0);
      check_val("reset_step", {29'b0, step_idx}, 32'h0);
      check_val("reset_rec", {31'b0, recording}, 32'h0);
      check_val("reset_period", {6'b0, period_dbg}, 32'h0);
      repeat (2) @(negedge clk); #1;
      check_val("reset_hold_pats", {ins4_pat, ins3_pat, ins2_pat, ins1_pat}, 32'h0);
      hit_v = 4'b0;
      release_reset();
      repeat (250) cyc();

      after_edge();
      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
